// File: rtl/osd_text_writer.sv
// Write-side sequencer for the 128-cell OSD character buffer: arbitrates two command
// requesters and expands PUTC / HEX16 / SETPOS / CLEAR into char-RAM writes.
module osd_text_writer #(
    parameter int         COLS   = 16,
    parameter int         ROWS   = 8,
    parameter int         ADDR_W = 7,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    localparam logic [1:0] OP_PUTC   = 2'b00;
    localparam logic [1:0] OP_HEX16  = 2'b01;
    localparam logic [1:0] OP_SETPOS = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_PUTC, S_HEX, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              last_grant_q, last_grant_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    logic              grant_idx;
    logic              take;
    logic [1:0]        sel_op;
    logic [15:0]       sel_data;
    logic [3:0]        nibble;
    logic [7:0]        hex_char;

    // Round-robin on ties: the requester that did not win last time goes first.
    always_comb begin
        grant_idx = 1'b0;
        req_ready = 2'b00;
        if (state_q == S_IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_idx = 1'b0;
                    req_ready = 2'b01;
                end
                2'b10: begin
                    grant_idx = 1'b1;
                    req_ready = 2'b10;
                end
                2'b11: begin
                    grant_idx = ~last_grant_q;
                    req_ready = grant_idx ? 2'b10 : 2'b01;
                end
                default: begin
                    grant_idx = 1'b0;
                    req_ready = 2'b00;
                end
            endcase
        end
    end

    assign take     = |req_ready;
    assign sel_op   = grant_idx ? req_op[3:2]     : req_op[1:0];
    assign sel_data = grant_idx ? req_data[31:16] : req_data[15:0];

    always_comb begin
        case (nib_cnt_q)
            2'd0:    nibble = data_q[15:12];
            2'd1:    nibble = data_q[11:8];
            2'd2:    nibble = data_q[7:4];
            default: nibble = data_q[3:0];
        endcase
        hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    end

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        nib_cnt_d    = nib_cnt_q;
        clr_addr_d   = clr_addr_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    last_grant_d = grant_idx;
                    data_d       = sel_data;
                    case (sel_op)
                        OP_PUTC:   state_d = S_PUTC;
                        OP_HEX16: begin
                            state_d   = S_HEX;
                            nib_cnt_d = 2'd0;
                        end
                        OP_SETPOS: cursor_d = sel_data[ADDR_W-1:0];
                        OP_CLEAR: begin
                            state_d    = S_CLEAR;
                            clr_addr_d = '0;
                        end
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_PUTC: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cursor_q;
                wr_data_d = data_q[7:0];
                cursor_d  = cursor_q + ONE;
                state_d   = S_IDLE;
            end
            S_HEX: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cursor_q;
                wr_data_d = hex_char;
                cursor_d  = cursor_q + ONE;
                nib_cnt_d = nib_cnt_q + 2'd1;
                if (nib_cnt_q == 2'd3) state_d = S_IDLE;
            end
            S_CLEAR: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = clr_addr_q;
                wr_data_d  = BLANK;
                clr_addr_d = clr_addr_q + ONE;
                if (clr_addr_q == LAST_CELL) begin
                    state_d  = S_IDLE;
                    cursor_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Reset also aborts any command in flight, dropping wr_en without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cursor_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            nib_cnt_q    <= '0;
            clr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            nib_cnt_q    <= nib_cnt_d;
            clr_addr_q   <= clr_addr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cursor  = cursor_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_osd_text_writer.sv
// Directed bench for osd_text_writer: a command table checked against logged RAM writes,
// plus hand sequences for arbitration, CLEAR and reset-abort.
module tb_osd_text_writer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_data;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor;
    logic        busy;

    osd_text_writer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor    (cursor),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              who;
        logic [1:0]      op;
        logic [15:0]     data;
        int              nWr;
        logic [3:0][6:0] expAddr;
        logic [3:0][7:0] expData;
        logic [6:0]      expCursor;
        int              expBusy;
    } vec_t;

    vec_t vecs[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int cycle       = 0;
    int busyCnt     = 0;
    logic [6:0] wrAddrQ[$];
    logic [7:0] wrDataQ[$];
    int         wrCycQ[$];

    // Passive log of every write strobe and busy cycle, sampled mid-cycle.
    always @(negedge clk) begin
        cycle++;
        if (wr_en) begin
            wrAddrQ.push_back(wr_addr);
            wrDataQ.push_back(wr_data);
            wrCycQ.push_back(cycle);
        end
        if (busy) busyCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearLog();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycQ.delete();
        busyCnt = 0;
    endtask

    // Called at a negedge; returns just after the transfer edge with valid dropped.
    task automatic applyStimulus(input int who, input logic [1:0] op, input logic [15:0] d, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        req_op[2*who +: 2]   = op;
        req_data[16*who +: 16] = d;
        req_valid[who]       = 1'b1;
        #1;
        while (n < 300 && !req_ready[who]) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_ready[who]) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[who] = 1'b0;
    endtask

    task automatic waitIdle(output bit ok);
        int n;
        ok = 1'b0;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!busy && !wr_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic void addVec(input int who, input logic [1:0] op, input logic [15:0] d, input int n,
                                   input logic [6:0] a0, input logic [7:0] d0, input logic [6:0] a1, input logic [7:0] d1,
                                   input logic [6:0] a2, input logic [7:0] d2, input logic [6:0] a3, input logic [7:0] d3,
                                   input logic [6:0] cur, input int bsy);
        vec_t v;
        v.who = who; v.op = op; v.data = d; v.nWr = n;
        v.expAddr = {a3, a2, a1, a0};
        v.expData = {d3, d2, d1, d0};
        v.expCursor = cur; v.expBusy = bsy;
        vecs.push_back(v);
    endfunction

    initial begin
        bit ok;
        int found;
        logic [1:0] expRdy[8];

        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_op    = 4'h0;
        req_data  = 32'h0;

        // PUTC=00 HEX16=01 SETPOS=10 CLEAR=11
        addVec(0, 2'b00, 16'h0041, 1, 7'd0, 8'h41, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd1, 1);
        addVec(1, 2'b00, 16'h5A7A, 1, 7'd1, 8'h7A, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd2, 1);
        addVec(0, 2'b10, 16'h007E, 0, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd126, 0);
        addVec(1, 2'b01, 16'hBEEF, 4, 7'd126, 8'h42, 7'd127, 8'h45, 7'd0, 8'h45, 7'd1, 8'h46, 7'd2, 4);
        addVec(0, 2'b01, 16'h09A0, 4, 7'd2, 8'h30, 7'd3, 8'h39, 7'd4, 8'h41, 7'd5, 8'h30, 7'd6, 4);
        addVec(1, 2'b10, 16'hFF85, 0, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd5, 0);
        addVec(0, 2'b00, 16'h00FF, 1, 7'd5, 8'hFF, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd6, 1);
        addVec(0, 2'b10, 16'h007F, 0, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd127, 0);
        addVec(1, 2'b00, 16'h1200, 1, 7'd127, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 1);

        repeat (2) @(negedge clk);
        checkOutput("rst_wr_en", {31'h0, wr_en}, 32'h0);
        checkOutput("rst_wr_addr", {25'h0, wr_addr}, 32'h0);
        checkOutput("rst_wr_data", {24'h0, wr_data}, 32'h0);
        checkOutput("rst_cursor", {25'h0, cursor}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_ready", {30'h0, req_ready}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #1 checkOutput("tie_ready", {30'h0, req_ready}, 32'h1);
        req_valid = 2'b10;
        #1 checkOutput("one_ready", {30'h0, req_ready}, 32'h2);
        req_valid = 2'b00;
        @(negedge clk);

        foreach (vecs[i]) begin
            clearLog();
            applyStimulus(vecs[i].who, vecs[i].op, vecs[i].data, ok);
            checkOutput($sformatf("v%0d_accept", i), {31'h0, ok}, 32'h1);
            waitIdle(ok);
            checkOutput($sformatf("v%0d_done", i), {31'h0, ok}, 32'h1);
            checkOutput($sformatf("v%0d_nwr", i), wrAddrQ.size(), vecs[i].nWr);
            for (int k = 0; k < vecs[i].nWr && k < wrAddrQ.size(); k++) begin
                checkOutput($sformatf("v%0d_addr%0d", i, k), {25'h0, wrAddrQ[k]}, {25'h0, vecs[i].expAddr[k]});
                checkOutput($sformatf("v%0d_data%0d", i, k), {24'h0, wrDataQ[k]}, {24'h0, vecs[i].expData[k]});
                checkOutput($sformatf("v%0d_gap%0d", i, k), wrCycQ[k] - wrCycQ[0], k);
            end
            checkOutput($sformatf("v%0d_cursor", i), {25'h0, cursor}, {25'h0, vecs[i].expCursor});
            checkOutput($sformatf("v%0d_busy", i), busyCnt, vecs[i].expBusy);
        end

        // Both requesters stream PUTC; after reset requester 0 wins the first tie.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clearLog();
        expRdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        req_op    = 4'b0000;
        req_data  = {16'h0062, 16'h0061};
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #1 checkOutput($sformatf("rr_ready%0d", c), {30'h0, req_ready}, {30'h0, expRdy[c]});
            @(negedge clk);
        end
        req_valid = 2'b00;
        waitIdle(ok);
        checkOutput("rr_done", {31'h0, ok}, 32'h1);
        checkOutput("rr_nwr", wrAddrQ.size(), 4);
        for (int k = 0; k < 4 && k < wrAddrQ.size(); k++) begin
            checkOutput($sformatf("rr_addr%0d", k), {25'h0, wrAddrQ[k]}, k);
            checkOutput($sformatf("rr_data%0d", k), {24'h0, wrDataQ[k]}, (k % 2 == 0) ? 32'h61 : 32'h62);
        end
        checkOutput("rr_cursor", {25'h0, cursor}, 32'd4);

        // CLEAR from a non-zero cursor.
        clearLog();
        applyStimulus(1, 2'b11, 16'h0000, ok);
        checkOutput("clr_accept", {31'h0, ok}, 32'h1);
        waitIdle(ok);
        checkOutput("clr_done", {31'h0, ok}, 32'h1);
        checkOutput("clr_nwr", wrAddrQ.size(), 128);
        for (int k = 0; k < 128 && k < wrAddrQ.size(); k++) begin
            checkOutput($sformatf("clr_addr%0d", k), {25'h0, wrAddrQ[k]}, k);
            checkOutput($sformatf("clr_data%0d", k), {24'h0, wrDataQ[k]}, 32'h20);
        end
        if (wrCycQ.size() == 128) checkOutput("clr_span", wrCycQ[127] - wrCycQ[0], 127);
        checkOutput("clr_busy", busyCnt, 128);
        checkOutput("clr_cursor", {25'h0, cursor}, 32'h0);

        // Reset in the middle of a CLEAR.
        applyStimulus(0, 2'b11, 16'h0000, ok);
        checkOutput("abort_accept", {31'h0, ok}, 32'h1);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 7'd50) begin
                found = 1;
                break;
            end
        end
        checkOutput("abort_reach50", found, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_wr_en", {31'h0, wr_en}, 32'h0);
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_cursor", {25'h0, cursor}, 32'h0);
        clearLog();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_nwr", wrAddrQ.size(), 0);
        checkOutput("abort_busy_after", busyCnt, 0);
        checkOutput("abort_cursor_after", {25'h0, cursor}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
